// File: rtl/mshr_alloc_ctrl_pkg.sv
// Shared MSHR allocation types: entry count, entry ID type and holder slot record.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package vc_mshr_pkg;

  localparam int ENTRY_NUM      = 32;
  localparam int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM);
  localparam int CNT_WIDTH      = $clog2(ENTRY_NUM + 1);

  typedef logic [ENTRY_ID_WIDTH-1:0] mshr_id_t;

  typedef struct packed {
    logic     v;
    mshr_id_t id;
  } holder_slot_t;

  // Decode an entry ID into a one-hot entry vector.
  function automatic logic [ENTRY_NUM-1:0] id_onehot(input mshr_id_t id);
    logic [ENTRY_NUM-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mshr_alloc_ctrl_if.sv
// Bundle of the pre-allocator, miss-request and release signals around the MSHR allocator.
// Latency: n/a (wiring only).
// Backpressure: pair_rdy gates pair acceptance, req_rdy gates request grants.
interface mshr_alloc_ctrl_if;
  import vc_mshr_pkg::*;

  logic [ENTRY_NUM-1:0] free_vld;
  logic [ENTRY_NUM-1:0] free_rdy;
  logic                 pair_vld;
  logic                 pair_rdy;
  mshr_id_t             pair_idx_1;
  mshr_id_t             pair_idx_2;
  logic                 req_vld;
  logic                 req_two;
  logic                 req_rdy;
  mshr_id_t             req_id_1;
  mshr_id_t             req_id_2;
  logic                 rel_vld;
  mshr_id_t             rel_idx;
  logic [CNT_WIDTH-1:0] busy_cnt;
  logic                 rel_err;

  // Environment side: pre-allocator, miss requester and release source.
  modport master (
    input  free_vld, pair_rdy, req_rdy, req_id_1, req_id_2, busy_cnt, rel_err,
    output free_rdy, pair_vld, pair_idx_1, pair_idx_2, req_vld, req_two, rel_vld, rel_idx
  );

  // Allocator side.
  modport slave (
    output free_vld, pair_rdy, req_rdy, req_id_1, req_id_2, busy_cnt, rel_err,
    input  free_rdy, pair_vld, pair_idx_1, pair_idx_2, req_vld, req_two, rel_vld, rel_idx
  );

endinterface

// File: rtl/mshr_alloc_ctrl_holder.sv
// Two-slot holder for pre-allocated ID pairs; grants one or two IDs per miss request.
// Latency: pair accepted at T is grantable at T+1; grant IDs are combinational on slot state.
// Backpressure: accepts a pair only when both slots are empty; recycles a lone slot for two-ID requests.
module mshr_alloc_holder
  import vc_mshr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pair_vld_i,
  input  mshr_id_t             pair_idx_1_i,
  input  mshr_id_t             pair_idx_2_i,
  output logic                 pair_rdy_o,
  input  logic                 req_vld_i,
  input  logic                 req_two_i,
  output logic                 req_rdy_o,
  output mshr_id_t             req_id_1_o,
  output mshr_id_t             req_id_2_o,
  output logic                 gnt_vld_o,
  output logic [ENTRY_NUM-1:0] gnt_oh_o,
  output logic [ENTRY_NUM-1:0] rcy_oh_o
);

  holder_slot_t a_q, a_d, b_q, b_d;
  logic         acc;
  logic         rcy;

  // Handshake decisions; all are functions of registered slot state plus inputs.
  always_comb begin
    pair_rdy_o = !a_q.v && !b_q.v;
    req_rdy_o  = req_two_i ? (a_q.v && b_q.v) : (a_q.v || b_q.v);
    gnt_vld_o  = req_vld_i && req_rdy_o;
    // A lone slot can never satisfy a two-ID request; give it back so a fresh pair can land.
    rcy        = req_vld_i && req_two_i && (a_q.v ^ b_q.v);
    acc        = pair_vld_i && pair_rdy_o;
  end

  // Granted IDs and the one-hot vectors that update the parent's bitmaps.
  always_comb begin
    req_id_1_o = '0;
    req_id_2_o = '0;
    gnt_oh_o   = '0;
    rcy_oh_o   = '0;
    if (gnt_vld_o) begin
      if (req_two_i) begin
        req_id_1_o = a_q.id;
        req_id_2_o = b_q.id;
        gnt_oh_o   = id_onehot(a_q.id) | id_onehot(b_q.id);
      end else begin
        req_id_1_o = a_q.v ? a_q.id : b_q.id;
        gnt_oh_o   = id_onehot(req_id_1_o);
      end
    end
    if (rcy) begin
      rcy_oh_o = id_onehot(a_q.v ? a_q.id : b_q.id);
    end
  end

  // Slot next state: load on pair acceptance, drop on grant or recycle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (acc) begin
      a_d = '{v: 1'b1, id: pair_idx_1_i};
      b_d = '{v: 1'b1, id: pair_idx_2_i};
    end
    if (gnt_vld_o) begin
      if (req_two_i) begin
        a_d.v = 1'b0;
        b_d.v = 1'b0;
      end else if (a_q.v) begin
        a_d.v = 1'b0;
      end else begin
        b_d.v = 1'b0;
      end
    end
    if (rcy) begin
      a_d.v = 1'b0;
      b_d.v = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  a_slot_ids_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    !(a_q.v && b_q.v && (a_q.id == b_q.id)));

endmodule

// File: rtl/mshr_alloc_ctrl.sv
// MSHR entry occupancy owner: busy/reserved bitmaps, free vector, release handling, busy counter.
// Latency: reservations, grants and releases take effect the cycle after they are seen.
// Backpressure: pair_rdy/req_rdy come from the holder; releases are always accepted.
module mshr_alloc_ctrl
  import vc_mshr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mshr_alloc_ctrl_if.slave  mshr_if
);

  logic [ENTRY_NUM-1:0] busy_q, busy_d;
  logic [ENTRY_NUM-1:0] resv_q, resv_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] gnt_num;
  logic                 rel_hit;
  logic                 gnt_vld;
  logic [ENTRY_NUM-1:0] gnt_oh;
  logic [ENTRY_NUM-1:0] rcy_oh;

  mshr_alloc_holder u_holder (
    .clk          (clk),
    .rst_n        (rst_n),
    .pair_vld_i   (mshr_if.pair_vld),
    .pair_idx_1_i (mshr_if.pair_idx_1),
    .pair_idx_2_i (mshr_if.pair_idx_2),
    .pair_rdy_o   (mshr_if.pair_rdy),
    .req_vld_i    (mshr_if.req_vld),
    .req_two_i    (mshr_if.req_two),
    .req_rdy_o    (mshr_if.req_rdy),
    .req_id_1_o   (mshr_if.req_id_1),
    .req_id_2_o   (mshr_if.req_id_2),
    .gnt_vld_o    (gnt_vld),
    .gnt_oh_o     (gnt_oh),
    .rcy_oh_o     (rcy_oh)
  );

  assign mshr_if.free_vld = ~busy_q & ~resv_q;
  assign mshr_if.busy_cnt = cnt_q;
  assign mshr_if.rel_err  = err_q;

  // Bitmap, counter and error next state. Granted IDs are reserved (never busy) and a
  // released ID must be busy, so the grant and release updates never touch the same bit.
  always_comb begin
    rel_hit = mshr_if.rel_vld && busy_q[mshr_if.rel_idx];
    resv_d  = (resv_q | mshr_if.free_rdy) & ~gnt_oh & ~rcy_oh;
    busy_d  = busy_q | gnt_oh;
    if (rel_hit) begin
      busy_d[mshr_if.rel_idx] = 1'b0;
    end
    gnt_num = '0;
    if (gnt_vld) begin
      gnt_num = mshr_if.req_two ? CNT_WIDTH'(2) : CNT_WIDTH'(1);
    end
    cnt_d = cnt_q + gnt_num - CNT_WIDTH'(rel_hit);
    err_d = err_q | (mshr_if.rel_vld && !busy_q[mshr_if.rel_idx]);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      resv_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      resv_q <= resv_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  a_busy_resv_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
    (busy_q & resv_q) == '0);
  a_cnt_matches_busy: assert property (@(posedge clk) disable iff (!rst_n)
    int'(cnt_q) == $countones(busy_q));
  a_rsv_only_free: assert property (@(posedge clk) disable iff (!rst_n)
    (mshr_if.free_rdy & ~mshr_if.free_vld) == '0);

endmodule

// File: tb/tb_mshr_alloc_ctrl.sv
// Self-checking bench for mshr_alloc_ctrl: directed scenarios plus randomized traffic.
// Latency: reference model advances once per clock alongside the design.
// Backpressure: random stimulus only reserves free entries and offers reserved IDs as pairs.
module tb_mshr_alloc_ctrl;
  import vc_mshr_pkg::*;
  localparam int N = ENTRY_NUM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mshr_alloc_ctrl_if bus ();
  mshr_alloc_ctrl dut (.clk(clk), .rst_n(rst_n), .mshr_if(bus));

  int total = 0;
  int bad = 0;

  // Reference model: occupancy as plain bit arrays, holder as an ordered queue of IDs.
  bit m_busy [N];
  bit m_resv [N];
  int m_hold [$];
  bit m_err;

  function automatic logic [N-1:0] m_free();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = !m_busy[i] && !m_resv[i];
    return f;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit m_req_rdy();
    return bus.req_two ? (m_hold.size() >= 2) : (m_hold.size() >= 1);
  endfunction

  function automatic int m_id1();
    if (bus.req_vld && m_req_rdy()) return m_hold[0];
    return 0;
  endfunction

  function automatic int m_id2();
    if (bus.req_vld && bus.req_two && m_req_rdy()) return m_hold[1];
    return 0;
  endfunction

  function automatic bit in_hold(int id);
    foreach (m_hold[k]) if (m_hold[k] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_busy[i] = 1'b0; m_resv[i] = 1'b0; end
    m_hold.delete();
    m_err = 1'b0;
  endtask

  task automatic idle();
    bus.free_rdy = '0; bus.pair_vld = 1'b0; bus.pair_idx_1 = '0; bus.pair_idx_2 = '0;
    bus.req_vld = 1'b0; bus.req_two = 1'b0; bus.rel_vld = 1'b0; bus.rel_idx = '0;
  endtask

  // Advance the model with the currently driven inputs, then let the clock edge pass.
  task automatic tick();
    int n; bit gnt; bit rec; bit acc; int id; int take;
    n = m_hold.size();
    gnt = bus.req_vld && m_req_rdy();
    rec = bus.req_vld && bus.req_two && (n == 1);
    acc = bus.pair_vld && (n == 0);
    take = bus.req_two ? 2 : 1;
    if (bus.rel_vld) begin
      if (m_busy[bus.rel_idx]) m_busy[bus.rel_idx] = 1'b0;
      else m_err = 1'b1;
    end
    for (int i = 0; i < N; i++) if (bus.free_rdy[i]) m_resv[i] = 1'b1;
    if (gnt) for (int k = 0; k < take; k++) begin
      id = m_hold.pop_front(); m_resv[id] = 1'b0; m_busy[id] = 1'b1;
    end
    if (rec) begin id = m_hold.pop_front(); m_resv[id] = 1'b0; end
    if (acc) begin m_hold.push_back(int'(bus.pair_idx_1)); m_hold.push_back(int'(bus.pair_idx_2)); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_pair(input int i1, input int i2);
    idle();
    bus.free_rdy[i1] = 1'b1; bus.free_rdy[i2] = 1'b1;
    bus.pair_vld = 1'b1; bus.pair_idx_1 = mshr_id_t'(i1); bus.pair_idx_2 = mshr_id_t'(i2);
    tick();
  endtask

  task automatic release_id(input int i);
    idle(); bus.rel_vld = 1'b1; bus.rel_idx = mshr_id_t'(i); tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    total++; if (bus.free_vld !== {N{1'b1}}) begin bad++; $display("FAIL reset_free_vld: got %h want %h", bus.free_vld, {N{1'b1}}); end
    total++; if (bus.pair_rdy !== 1'b1) begin bad++; $display("FAIL reset_pair_rdy: got %b want 1", bus.pair_rdy); end
    total++; if (bus.req_rdy !== 1'b0) begin bad++; $display("FAIL reset_req_rdy: got %b want 0", bus.req_rdy); end
    total++; if (bus.busy_cnt !== '0) begin bad++; $display("FAIL reset_busy_cnt: got %0d want 0", bus.busy_cnt); end
    total++; if (bus.req_id_1 !== '0 || bus.req_id_2 !== '0) begin bad++; $display("FAIL reset_req_id: got %0d/%0d want 0/0", bus.req_id_1, bus.req_id_2); end
    total++; if (bus.rel_err !== 1'b0) begin bad++; $display("FAIL reset_rel_err: got %b want 0", bus.rel_err); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pair_accept();
    idle();
    bus.free_rdy[3] = 1'b1; bus.free_rdy[7] = 1'b1;
    bus.pair_vld = 1'b1; bus.pair_idx_1 = 5'd3; bus.pair_idx_2 = 5'd7;
    #1;
    total++; if (bus.pair_rdy !== 1'b1) begin bad++; $display("FAIL accept_pair_rdy: got %b want 1", bus.pair_rdy); end
    total++; if (bus.req_rdy !== 1'b0) begin bad++; $display("FAIL accept_req_rdy_early: got %b want 0", bus.req_rdy); end
    tick();
    idle(); bus.req_two = 1'b1;
    #1;
    total++; if (bus.free_vld[3] !== 1'b0 || bus.free_vld[7] !== 1'b0) begin bad++; $display("FAIL accept_free_vld: got %b%b want 00", bus.free_vld[3], bus.free_vld[7]); end
    total++; if (bus.pair_rdy !== 1'b0) begin bad++; $display("FAIL accept_pair_rdy_fall: got %b want 0", bus.pair_rdy); end
    total++; if (bus.req_rdy !== 1'b1) begin bad++; $display("FAIL accept_req_rdy_rise: got %b want 1", bus.req_rdy); end
  endtask

  task automatic test_two_grant();
    idle(); bus.req_vld = 1'b1; bus.req_two = 1'b1;
    #1;
    total++; if (bus.req_rdy !== 1'b1) begin bad++; $display("FAIL two_req_rdy: got %b want 1", bus.req_rdy); end
    total++; if (bus.req_id_1 !== 5'd3 || bus.req_id_2 !== 5'd7) begin bad++; $display("FAIL two_ids: got %0d/%0d want 3/7", bus.req_id_1, bus.req_id_2); end
    tick();
    idle();
    #1;
    total++; if (bus.busy_cnt !== 6'd2) begin bad++; $display("FAIL two_busy_cnt: got %0d want 2", bus.busy_cnt); end
    total++; if (bus.pair_rdy !== 1'b1) begin bad++; $display("FAIL two_pair_rdy: got %b want 1", bus.pair_rdy); end
    release_id(3);
    release_id(7);
    #1;
    total++; if (bus.busy_cnt !== 6'd0 || bus.free_vld !== {N{1'b1}}) begin bad++; $display("FAIL two_release: got cnt=%0d free=%h want 0/all ones", bus.busy_cnt, bus.free_vld); end
  endtask

  task automatic test_one_grant();
    load_pair(3, 7);
    idle(); bus.req_vld = 1'b1;
    #1;
    total++; if (bus.req_id_1 !== 5'd3 || bus.req_id_2 !== 5'd0) begin bad++; $display("FAIL one_first: got %0d/%0d want 3/0", bus.req_id_1, bus.req_id_2); end
    tick();
    idle(); bus.req_vld = 1'b1;
    #1;
    total++; if (bus.pair_rdy !== 1'b0) begin bad++; $display("FAIL one_pair_rdy_mid: got %b want 0", bus.pair_rdy); end
    total++; if (bus.req_id_1 !== 5'd7 || bus.req_id_2 !== 5'd0) begin bad++; $display("FAIL one_second: got %0d/%0d want 7/0", bus.req_id_1, bus.req_id_2); end
    tick();
    idle();
    #1;
    total++; if (bus.pair_rdy !== 1'b1 || bus.busy_cnt !== 6'd2) begin bad++; $display("FAIL one_after: got rdy=%b cnt=%0d want 1/2", bus.pair_rdy, bus.busy_cnt); end
  endtask

  task automatic test_recycle();
    release_id(3);
    release_id(7);
    load_pair(3, 7);
    idle(); bus.req_vld = 1'b1;
    tick();
    // Only slot B (ID 7) remains; a two-ID request must recycle it.
    idle(); bus.req_vld = 1'b1; bus.req_two = 1'b1;
    #1;
    total++; if (bus.req_rdy !== 1'b0 || bus.req_id_1 !== 5'd0) begin bad++; $display("FAIL rcy_no_grant: got rdy=%b id=%0d want 0/0", bus.req_rdy, bus.req_id_1); end
    total++; if (bus.free_vld[7] !== 1'b0) begin bad++; $display("FAIL rcy_held: got %b want 0", bus.free_vld[7]); end
    tick();
    bus.free_rdy[1] = 1'b1; bus.free_rdy[2] = 1'b1;
    bus.pair_vld = 1'b1; bus.pair_idx_1 = 5'd1; bus.pair_idx_2 = 5'd2;
    #1;
    total++; if (bus.free_vld[7] !== 1'b1) begin bad++; $display("FAIL rcy_free7: got %b want 1", bus.free_vld[7]); end
    total++; if (bus.pair_rdy !== 1'b1 || bus.req_rdy !== 1'b0) begin bad++; $display("FAIL rcy_empty: got pair_rdy=%b req_rdy=%b want 1/0", bus.pair_rdy, bus.req_rdy); end
    tick();
    idle(); bus.req_vld = 1'b1; bus.req_two = 1'b1;
    #1;
    total++; if (bus.req_rdy !== 1'b1 || bus.req_id_1 !== 5'd1 || bus.req_id_2 !== 5'd2) begin bad++; $display("FAIL rcy_grant: got rdy=%b ids=%0d/%0d want 1 1/2", bus.req_rdy, bus.req_id_1, bus.req_id_2); end
    tick();
    idle();
    #1;
    total++; if (bus.busy_cnt !== 6'd3) begin bad++; $display("FAIL rcy_busy_cnt: got %0d want 3", bus.busy_cnt); end
  endtask

  task automatic test_grant_release();
    load_pair(5, 9);
    idle(); bus.req_vld = 1'b1;
    tick();
    idle(); bus.req_vld = 1'b1; bus.rel_vld = 1'b1; bus.rel_idx = 5'd5;
    #1;
    total++; if (bus.req_id_1 !== 5'd9) begin bad++; $display("FAIL gr_id: got %0d want 9", bus.req_id_1); end
    tick();
    idle();
    #1;
    total++; if (bus.busy_cnt !== 6'd4) begin bad++; $display("FAIL gr_busy_cnt: got %0d want 4", bus.busy_cnt); end
    total++; if (bus.free_vld[5] !== 1'b1 || bus.free_vld[9] !== 1'b0) begin bad++; $display("FAIL gr_free: got f5=%b f9=%b want 1/0", bus.free_vld[5], bus.free_vld[9]); end
    release_id(9);
    #1;
    total++; if (bus.rel_err !== 1'b0 || bus.busy_cnt !== 6'd3) begin bad++; $display("FAIL gr_busy9: got err=%b cnt=%0d want 0/3", bus.rel_err, bus.busy_cnt); end
  endtask

  task automatic test_rel_err();
    release_id(12);
    #1;
    total++; if (bus.rel_err !== 1'b1 || bus.busy_cnt !== 6'd3) begin bad++; $display("FAIL err_set: got err=%b cnt=%0d want 1/3", bus.rel_err, bus.busy_cnt); end
    idle();
    repeat (3) tick();
    #1;
    total++; if (bus.rel_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.rel_err); end
  endtask

  task automatic test_random();
    int pool[$]; int busy_ids[$]; int a; int b; int r; logic [N-1:0] fm;
    for (int c = 0; c < 1500; c++) begin
      idle();
      fm = m_free();
      for (int i = 0; i < N; i++) if (fm[i] && $urandom_range(0, 7) == 0) bus.free_rdy[i] = 1'b1;
      pool.delete(); busy_ids.delete();
      for (int i = 0; i < N; i++) begin
        if (m_resv[i] && !in_hold(i)) pool.push_back(i);
        if (m_busy[i]) busy_ids.push_back(i);
      end
      if (pool.size() >= 2 && $urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(0, pool.size() - 1));
        b = (a + 1 + int'($urandom_range(0, pool.size() - 2))) % pool.size();
        bus.pair_vld = 1'b1; bus.pair_idx_1 = mshr_id_t'(pool[a]); bus.pair_idx_2 = mshr_id_t'(pool[b]);
      end
      bus.req_vld = 1'($urandom_range(0, 1));
      bus.req_two = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      if (r < 30 && busy_ids.size() > 0) begin
        bus.rel_vld = 1'b1; bus.rel_idx = mshr_id_t'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
      end else if (r < 31) begin
        bus.rel_vld = 1'b1; bus.rel_idx = mshr_id_t'($urandom_range(0, N - 1));
      end
      #1;
      total++; if (bus.free_vld !== m_free()) begin bad++; $display("FAIL rnd_free_vld c=%0d: got %h want %h", c, bus.free_vld, m_free()); end
      total++; if (bus.pair_rdy !== (m_hold.size() == 0)) begin bad++; $display("FAIL rnd_pair_rdy c=%0d: got %b want %b", c, bus.pair_rdy, m_hold.size() == 0); end
      total++; if (bus.req_rdy !== m_req_rdy()) begin bad++; $display("FAIL rnd_req_rdy c=%0d: got %b want %b", c, bus.req_rdy, m_req_rdy()); end
      total++; if (bus.req_id_1 !== mshr_id_t'(m_id1()) || bus.req_id_2 !== mshr_id_t'(m_id2())) begin bad++; $display("FAIL rnd_req_id c=%0d: got %0d/%0d want %0d/%0d", c, bus.req_id_1, bus.req_id_2, m_id1(), m_id2()); end
      total++; if (bus.busy_cnt !== CNT_WIDTH'(m_cnt())) begin bad++; $display("FAIL rnd_busy_cnt c=%0d: got %0d want %0d", c, bus.busy_cnt, m_cnt()); end
      total++; if (bus.rel_err !== m_err) begin bad++; $display("FAIL rnd_rel_err c=%0d: got %b want %b", c, bus.rel_err, m_err); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int pool[$]; logic [N-1:0] fm; int got;
    for (int i = 0; i < N; i++) if (m_busy[i]) release_id(i);
    if (m_hold.size() == 0) begin
      for (int i = 0; i < N; i++) if (m_resv[i]) pool.push_back(i);
      if (pool.size() >= 2) begin
        idle(); bus.pair_vld = 1'b1;
        bus.pair_idx_1 = mshr_id_t'(pool[0]); bus.pair_idx_2 = mshr_id_t'(pool[1]);
        tick();
      end else begin
        fm = m_free(); got = 0;
        idle(); bus.pair_vld = 1'b1;
        for (int i = 0; i < N; i++) if (fm[i] && got < 2) begin
          bus.free_rdy[i] = 1'b1;
          if (got == 0) bus.pair_idx_1 = mshr_id_t'(i); else bus.pair_idx_2 = mshr_id_t'(i);
          got++;
        end
        tick();
      end
    end
    idle(); bus.req_vld = 1'b1;
    #1;
    total++; if (bus.req_rdy !== 1'b1) begin bad++; $display("FAIL mid_pre_rdy: got %b want 1", bus.req_rdy); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.free_vld !== {N{1'b1}}) begin bad++; $display("FAIL mid_free_vld: got %h want %h", bus.free_vld, {N{1'b1}}); end
    total++; if (bus.pair_rdy !== 1'b1 || bus.req_rdy !== 1'b0 || bus.req_id_1 !== 5'd0) begin bad++; $display("FAIL mid_holder: got pair_rdy=%b req_rdy=%b id=%0d want 1/0/0", bus.pair_rdy, bus.req_rdy, bus.req_id_1); end
    total++; if (bus.rel_err !== 1'b0 || bus.busy_cnt !== '0) begin bad++; $display("FAIL mid_err_cnt: got err=%b cnt=%0d want 0/0", bus.rel_err, bus.busy_cnt); end
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    total++; if (bus.free_vld !== {N{1'b1}} || bus.pair_rdy !== 1'b1) begin bad++; $display("FAIL mid_after: got free=%h pair_rdy=%b want all ones/1", bus.free_vld, bus.pair_rdy); end
  endtask

  initial begin
    test_reset();
    test_pair_accept();
    test_two_grant();
    test_one_grant();
    test_recycle();
    test_grant_release();
    test_rel_err();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
